// File: rtl/button_conditioner.sv
// Pushbutton front end: per-channel 2-flop synchroniser, debounce FSM, and
// registered one-cycle press / release / long-press / auto-repeat pulses.
module button_conditioner #(
  parameter int N_BTN           = 5,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int LONG_CYCLES     = 100_000_000,
  parameter int REPEAT_CYCLES   = 20_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_long,
  output logic [N_BTN-1:0] btn_repeat
);

  localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  // hold_cnt must be able to hold LONG_CYCLES itself, where it saturates.
  localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
  localparam int REP_W  = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  logic [N_BTN-1:0] sync1_reg;
  logic [N_BTN-1:0] sync2_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= btn_in;
      sync2_reg <= sync1_reg;
    end
  end

  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_chan
    state_t            state_reg, state_next;
    logic [DB_W-1:0]   db_cnt_reg, db_cnt_next;
    logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
    logic [REP_W-1:0]  rep_cnt_reg, rep_cnt_next;
    logic              level_reg, level_next;
    logic              press_reg, press_next;
    logic              release_reg, release_next;
    logic              long_reg, long_next;
    logic              repeat_reg, repeat_next;
    logic              advance;
    logic              s;

    assign s = sync2_reg[gi];

    always_comb begin
      state_next    = state_reg;
      db_cnt_next   = db_cnt_reg;
      hold_cnt_next = hold_cnt_reg;
      rep_cnt_next  = rep_cnt_reg;
      level_next    = level_reg;
      press_next    = 1'b0;
      release_next  = 1'b0;
      long_next     = 1'b0;
      repeat_next   = 1'b0;
      advance       = 1'b0;

      case (state_reg)
        RELEASED: begin
          if (s) begin
            state_next  = PRESS_WAIT;
            db_cnt_next = '0;
          end
        end
        PRESS_WAIT: begin
          if (!s) begin
            state_next = RELEASED;
          end else if (db_cnt_reg == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            state_next    = PRESSED;
            press_next    = 1'b1;
            level_next    = 1'b1;
            hold_cnt_next = '0;
            rep_cnt_next  = '0;
          end else begin
            db_cnt_next = db_cnt_reg + 1'b1;
          end
        end
        PRESSED: begin
          if (!s) begin
            state_next  = RELEASE_WAIT;
            db_cnt_next = '0;
          end else begin
            advance = 1'b1;
          end
        end
        RELEASE_WAIT: begin
          // The return cycle counts as held time, so a glitch costs exactly
          // as many cycles as the synchronised input was low.
          if (s) begin
            state_next = PRESSED;
            advance    = 1'b1;
          end else if (db_cnt_reg == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            state_next    = RELEASED;
            release_next  = 1'b1;
            level_next    = 1'b0;
            hold_cnt_next = '0;
            rep_cnt_next  = '0;
          end else begin
            db_cnt_next = db_cnt_reg + 1'b1;
          end
        end
        default: begin
          state_next = RELEASED;
        end
      endcase

      if (advance) begin
        if (hold_cnt_reg != HOLD_W'(LONG_CYCLES)) begin
          hold_cnt_next = hold_cnt_reg + 1'b1;
          if (hold_cnt_reg == HOLD_W'(LONG_CYCLES - 1)) begin
            long_next = 1'b1;
          end
        end else if (REPEAT_CYCLES != 0) begin
          if (rep_cnt_reg == REP_W'(REPEAT_CYCLES - 1)) begin
            rep_cnt_next = '0;
            repeat_next  = 1'b1;
          end else begin
            rep_cnt_next = rep_cnt_reg + 1'b1;
          end
        end
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        state_reg    <= RELEASED;
        db_cnt_reg   <= '0;
        hold_cnt_reg <= '0;
        rep_cnt_reg  <= '0;
        level_reg    <= 1'b0;
        press_reg    <= 1'b0;
        release_reg  <= 1'b0;
        long_reg     <= 1'b0;
        repeat_reg   <= 1'b0;
      end else begin
        state_reg    <= state_next;
        db_cnt_reg   <= db_cnt_next;
        hold_cnt_reg <= hold_cnt_next;
        rep_cnt_reg  <= rep_cnt_next;
        level_reg    <= level_next;
        press_reg    <= press_next;
        release_reg  <= release_next;
        long_reg     <= long_next;
        repeat_reg   <= repeat_next;
      end
    end

    assign btn_level[gi]   = level_reg;
    assign btn_press[gi]   = press_reg;
    assign btn_release[gi] = release_reg;
    assign btn_long[gi]    = long_reg;
    assign btn_repeat[gi]  = repeat_reg;
  end

endmodule
